// File: rtl/mp64_mem_arbiter_if.sv
// Signal bundle between the I-cache refill port, the CPU data port and the
// core's single 64-bit memory master port.
interface mp64_mem_arbiter_if;
  logic        i_valid;
  logic [63:0] i_addr;
  logic [63:0] i_rdata;
  logic        i_ready;

  logic        d_valid;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_wen;
  logic [1:0]  d_size;
  logic [63:0] d_rdata;
  logic        d_ready;

  logic        m_valid;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic        m_wen;
  logic [1:0]  m_size;
  logic [63:0] m_rdata;
  logic        m_ready;

  // Arbiter view: takes the two core-side requests, drives the bus request.
  modport slave (
    input  i_valid, i_addr,
    output i_rdata, i_ready,
    input  d_valid, d_addr, d_wdata, d_wen, d_size,
    output d_rdata, d_ready,
    output m_valid, m_addr, m_wdata, m_wen, m_size,
    input  m_rdata, m_ready
  );

  // Core/bus view: issues the requests and answers the bus beats.
  modport master (
    output i_valid, i_addr,
    input  i_rdata, i_ready,
    output d_valid, d_addr, d_wdata, d_wen, d_size,
    input  d_rdata, d_ready,
    input  m_valid, m_addr, m_wdata, m_wen, m_size,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/mp64_mem_arbiter.sv
// Shares one 64-bit memory bus between I-cache refills and the data port,
// and generates the I-cache invalidate pulses (deferred inv-all, store snoop).
module mp64_mem_arbiter #(
  parameter logic [63:0] CODE_LO = 64'h0000_0000_0000_0000,
  parameter logic [63:0] CODE_HI = 64'h0000_0000_0010_0000
) (
  input  logic                clk,
  input  logic                rst,
  mp64_mem_arbiter_if.slave   bus,
  input  logic                csr_inv_all,
  output logic                ic_inv_all,
  output logic                ic_inv_line,
  output logic [63:0]         ic_inv_addr,
  output logic [63:0]         stat_i_beats,
  output logic [63:0]         stat_d_beats,
  output logic [63:0]         stat_conflicts
);

  // state | meaning
  // IDLE  | no owner; arbitrate, ties go to the port that did not own last
  // GNT_I | I-cache refill owns the bus until i_valid drops
  // GNT_D | data port owns the bus until d_valid drops
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [1:0]  BUS_DWORD = 2'd3;
  localparam logic [63:0] WIN_SPAN  = CODE_HI - CODE_LO;
  localparam logic        WIN_EN    = (CODE_HI > CODE_LO);

  state_t      state_q, state_d;
  logic        last_i_q, last_i_d;
  logic        inv_pend_q, inv_pend_d;
  logic        inv_all_q, inv_all_d;
  logic        inv_line_q, inv_line_d;
  logic [63:0] inv_addr_q, inv_addr_d;
  logic [63:0] i_beats_q, i_beats_d;
  logic [63:0] d_beats_q, d_beats_d;
  logic [63:0] confl_q, confl_d;
  logic        in_win;
  logic        snoop_hit;
  logic        inv_fire;
  logic        conflict;

  always_comb begin
    state_d  = state_q;
    last_i_d = last_i_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid && bus.d_valid) state_d = last_i_q ? GNT_D : GNT_I;
        else if (bus.i_valid)           state_d = GNT_I;
        else if (bus.d_valid)           state_d = GNT_D;
      end
      GNT_I: begin
        if (!bus.i_valid) begin
          state_d  = IDLE;
          last_i_d = 1'b1;
        end
      end
      GNT_D: begin
        if (!bus.d_valid) begin
          state_d  = IDLE;
          last_i_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.i_rdata = bus.m_rdata;
    bus.d_rdata = bus.m_rdata;
    bus.i_ready = 1'b0;
    bus.d_ready = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wen   = 1'b0;
    bus.m_size  = '0;
    case (state_q)
      GNT_I: begin
        bus.m_valid = bus.i_valid;
        bus.m_addr  = bus.i_addr;
        bus.m_size  = BUS_DWORD;
        bus.i_ready = bus.m_ready;
      end
      GNT_D: begin
        bus.m_valid = bus.d_valid;
        bus.m_addr  = bus.d_addr;
        bus.m_wdata = bus.d_wdata;
        bus.m_wen   = bus.d_wen;
        bus.m_size  = bus.d_size;
        bus.d_ready = bus.m_ready;
      end
      default: ;
    endcase
  end

  // Window test as an offset compare so a zero lower bound needs no special case.
  always_comb begin
    in_win     = WIN_EN && ((bus.d_addr - CODE_LO) < WIN_SPAN);
    snoop_hit  = (state_q == GNT_D) && bus.d_valid && bus.d_wen && bus.m_ready && in_win;
    inv_fire   = inv_pend_q && (state_q != GNT_I);
    conflict   = ((state_q == GNT_I) && bus.d_valid) || ((state_q == GNT_D) && bus.i_valid);

    inv_line_d = snoop_hit;
    inv_addr_d = snoop_hit ? bus.d_addr : inv_addr_q;
    inv_all_d  = inv_fire;
    // A request arriving while one is already pending is absorbed into it.
    inv_pend_d = inv_pend_q ? !inv_fire : csr_inv_all;

    i_beats_d  = i_beats_q + {63'd0, bus.i_ready};
    d_beats_d  = d_beats_q + {63'd0, bus.d_ready};
    confl_d    = confl_q + {63'd0, conflict};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_i_q   <= 1'b0;
      inv_pend_q <= 1'b0;
      inv_all_q  <= 1'b0;
      inv_line_q <= 1'b0;
      inv_addr_q <= '0;
      i_beats_q  <= '0;
      d_beats_q  <= '0;
      confl_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_i_q   <= last_i_d;
      inv_pend_q <= inv_pend_d;
      inv_all_q  <= inv_all_d;
      inv_line_q <= inv_line_d;
      inv_addr_q <= inv_addr_d;
      i_beats_q  <= i_beats_d;
      d_beats_q  <= d_beats_d;
      confl_q    <= confl_d;
    end
  end

  assign ic_inv_all     = inv_all_q;
  assign ic_inv_line    = inv_line_q;
  assign ic_inv_addr    = inv_addr_q;
  assign stat_i_beats   = i_beats_q;
  assign stat_d_beats   = d_beats_q;
  assign stat_conflicts = confl_q;

endmodule

// File: tb/tb_mp64_mem_arbiter.sv
// Scoreboard bench for mp64_mem_arbiter: drivers queue the expected bus beats,
// a monitor checks every completed beat, snoop pulses and round-robin order.
module tb_mp64_mem_arbiter;
  localparam logic [63:0] CODE_LO = 64'h0000_0000_0000_0000;
  localparam logic [63:0] CODE_HI = 64'h0000_0000_0010_0000;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        wen;
    logic [1:0]  size;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_inv_all;
  logic        ic_inv_all, ic_inv_line;
  logic [63:0] ic_inv_addr, stat_i_beats, stat_d_beats, stat_conflicts;

  int          checks = 0;
  int          errors = 0;
  beat_t       iq[$];
  beat_t       dq[$];
  bit          bus_auto = 1'b0;
  int unsigned rdy_pct = 60;
  logic        man_ready = 1'b0;
  bit          exp_line = 1'b0;
  logic [63:0] exp_line_addr = '0;
  int          inv_all_seen = 0;
  int          must_next = -1;
  bit          i_second = 1'b0;
  logic [63:0] win_lo = CODE_LO;
  logic [63:0] win_hi = CODE_HI;

  mp64_mem_arbiter_if bus ();

  mp64_mem_arbiter #(.CODE_LO(CODE_LO), .CODE_HI(CODE_HI)) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .csr_inv_all    (csr_inv_all),
    .ic_inv_all     (ic_inv_all),
    .ic_inv_line    (ic_inv_line),
    .ic_inv_addr    (ic_inv_addr),
    .stat_i_beats   (stat_i_beats),
    .stat_d_beats   (stat_d_beats),
    .stat_conflicts (stat_conflicts)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_fn(input logic [63:0] a);
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic bit in_win(input logic [63:0] a);
    return (a >= win_lo) && (a < win_hi);
  endfunction

  assign bus.m_rdata = mem_fn(bus.m_addr);

  // Bus model: decides the beat-complete strobe once per cycle, mid-cycle.
  always @(negedge clk) begin
    #1;
    bus.m_ready = bus_auto ? (bus.m_valid && ($urandom_range(0, 99) < rdy_pct)) : man_ready;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #2;
  endtask

  task automatic cmp_beat(input string p, input beat_t e, input logic [63:0] rdata);
    chk({p, "_m_addr"},  bus.m_addr,  e.addr);
    chk({p, "_m_wdata"}, bus.m_wdata, e.wdata);
    chk({p, "_m_wen"},   bus.m_wen,   e.wen);
    chk({p, "_m_size"},  bus.m_size,  e.size);
    chk({p, "_rdata"},   rdata,       mem_fn(e.addr));
  endtask

  task automatic txn_start(input int p);
    if (must_next >= 0) chk("rr_grant_port", p, must_next);
    must_next = -1;
  endtask

  // Monitor: checks each completed beat against the queued expectation.
  always begin
    beat_t e;
    samp();
    if (rst) begin
      iq.delete();
      dq.delete();
      exp_line  = 1'b0;
      must_next = -1;
      i_second  = 1'b0;
    end else begin
      chk("ic_inv_line", ic_inv_line, exp_line);
      if (exp_line) chk("ic_inv_addr", ic_inv_addr, exp_line_addr);
      exp_line = 1'b0;
      if (ic_inv_all) inv_all_seen++;
      if (bus.i_ready || bus.d_ready) begin
        chk("ready_exclusive", bus.i_ready & bus.d_ready, 0);
        chk("ready_with_m_ready", bus.m_ready, 1);
        if (bus.i_ready) begin
          if (iq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL i_beat: unexpected beat at 0x%0h, expected none", bus.m_addr);
          end else begin
            e = iq.pop_front();
            cmp_beat("i", e, bus.i_rdata);
            if (!i_second) txn_start(0);
            else if (bus.d_valid) must_next = 1;
            i_second = !i_second;
          end
        end else begin
          if (dq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL d_beat: unexpected beat at 0x%0h, expected none", bus.m_addr);
          end else begin
            e = dq.pop_front();
            cmp_beat("d", e, bus.d_rdata);
            txn_start(1);
            if (bus.i_valid) must_next = 0;
            if (e.wen && in_win(e.addr)) begin
              exp_line      = 1'b1;
              exp_line_addr = e.addr;
            end
          end
        end
      end
    end
  end

  task automatic push_i(input logic [63:0] base);
    beat_t e;
    e.addr = base; e.wdata = '0; e.wen = 1'b0; e.size = 2'd3;
    iq.push_back(e);
    e.addr = base + 64'd8;
    iq.push_back(e);
  endtask

  task automatic push_d(input logic [63:0] a, input logic [63:0] wd, input logic wen, input logic [1:0] sz);
    beat_t e;
    e.addr = a; e.wdata = wd; e.wen = wen; e.size = sz;
    dq.push_back(e);
    bus.d_addr = a; bus.d_wdata = wd; bus.d_wen = wen; bus.d_size = sz;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_addr = '0;
    bus.d_valid = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wen = 1'b0; bus.d_size = '0;
    csr_inv_all = 1'b0;
    man_ready   = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_ready(input bit is_d, input string nm);
    int n = 0;
    forever begin
      samp();
      if (is_d ? bus.d_ready : bus.i_ready) break;
      n++;
      if (n > 500) begin
        checks++;
        errors++;
        $display("FAIL %s: no ready within 500 cycles, expected a beat", nm);
        break;
      end
    end
  endtask

  task automatic d_store(input logic [63:0] a, input bit pulse);
    tick();
    push_d(a, {$urandom, $urandom}, 1'b1, 2'd3);
    bus.d_valid = 1'b1;
    tick();
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    bus.d_valid = 1'b0;
    samp();
    chk("snoop_pulse", ic_inv_line, pulse);
    if (pulse) chk("snoop_addr", ic_inv_addr, a);
    tick();
    samp();
    chk("snoop_one_cycle", ic_inv_line, 0);
  endtask

  task automatic i_driver(input int n);
    for (int k = 0; k < n; k++) begin
      logic [63:0] base;
      repeat ($urandom_range(1, 3)) tick();
      base = {32'd0, $urandom};
      base[3:0] = 4'd0;
      push_i(base);
      bus.i_valid = 1'b1;
      bus.i_addr  = base;
      wait_ready(1'b0, "i_beat0_wait");
      tick();
      bus.i_addr = base + 64'd8;
      wait_ready(1'b0, "i_beat1_wait");
      tick();
      bus.i_valid = 1'b0;
    end
  endtask

  task automatic d_driver(input int n);
    for (int k = 0; k < n; k++) begin
      logic [63:0] a;
      logic [31:0] r;
      repeat ($urandom_range(1, 4)) tick();
      r = $urandom;
      if ($urandom_range(0, 1) == 1) a = {44'd0, r[19:0]};
      else                           a = {32'd0, r} | 64'h0000_0000_0020_0000;
      a[2:0] = 3'd0;
      push_d(a, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      bus.d_valid = 1'b1;
      wait_ready(1'b1, "d_beat_wait");
      tick();
      bus.d_valid = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    do_reset();

    // Reset values
    samp();
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_m_wen", bus.m_wen, 0);
    chk("rst_m_size", bus.m_size, 0);
    chk("rst_i_ready", bus.i_ready, 0);
    chk("rst_d_ready", bus.d_ready, 0);
    chk("rst_stat_i", stat_i_beats, 0);
    chk("rst_stat_d", stat_d_beats, 0);
    chk("rst_stat_conf", stat_conflicts, 0);
    chk("rst_inv_all", ic_inv_all, 0);
    chk("rst_inv_addr", ic_inv_addr, 0);

    // I-only refill with m_ready on presented cycles 2 and 4
    tick();
    push_i(64'h1230);
    bus.i_valid = 1'b1;
    bus.i_addr  = 64'h1230;
    samp();
    chk("refill_arb_cycle_m_valid", bus.m_valid, 0);
    tick();
    samp();
    chk("refill_p1_m_valid", bus.m_valid, 1);
    chk("refill_p1_m_addr", bus.m_addr, 64'h1230);
    chk("refill_p1_i_ready", bus.i_ready, 0);
    tick();
    man_ready = 1'b1;
    samp();
    chk("refill_p2_i_ready", bus.i_ready, 1);
    tick();
    man_ready = 1'b0;
    bus.i_addr = 64'h1238;
    samp();
    chk("refill_p3_m_addr", bus.m_addr, 64'h1238);
    chk("refill_p3_i_ready", bus.i_ready, 0);
    tick();
    man_ready = 1'b1;
    samp();
    chk("refill_p4_i_ready", bus.i_ready, 1);
    tick();
    man_ready = 1'b0;
    bus.i_valid = 1'b0;
    tick();
    samp();
    chk("refill_stat_i", stat_i_beats, 2);
    chk("refill_idle_m_valid", bus.m_valid, 0);

    // Simultaneous first requests: I wins, D waits 3 GNT_I cycles
    do_reset();
    tick();
    push_i(64'h8000);
    bus.i_valid = 1'b1;
    bus.i_addr  = 64'h8000;
    push_d(64'h5008, 64'h1111_2222_3333_4444, 1'b0, 2'd2);
    bus.d_valid = 1'b1;
    tick();
    man_ready = 1'b1;
    samp();
    chk("tie_first_grant_addr", bus.m_addr, 64'h8000);
    tick();
    bus.i_addr = 64'h8008;
    tick();
    man_ready = 1'b0;
    bus.i_valid = 1'b0;
    tick();
    samp();
    chk("tie_gap_m_valid", bus.m_valid, 0);
    tick();
    man_ready = 1'b1;
    samp();
    chk("tie_second_grant_addr", bus.m_addr, 64'h5008);
    chk("tie_d_ready", bus.d_ready, 1);
    tick();
    man_ready = 1'b0;
    bus.d_valid = 1'b0;
    tick();
    samp();
    chk("tie_stat_conflicts", stat_conflicts, 3);
    chk("tie_stat_d", stat_d_beats, 1);
    chk("tie_stat_i", stat_i_beats, 2);

    // Store snoop across the window edges
    d_store(64'h400, 1'b1);
    d_store(64'h20_0000, 1'b0);
    d_store(64'hF_FFF8, 1'b1);
    d_store(64'h10_0000, 1'b0);
    d_store(64'h0, 1'b1);

    // inv_all requested twice during a refill: one pulse after release
    s0 = inv_all_seen;
    tick();
    push_i(64'h2000);
    bus.i_valid = 1'b1;
    bus.i_addr  = 64'h2000;
    tick();
    csr_inv_all = 1'b1;
    tick();
    csr_inv_all = 1'b0;
    man_ready = 1'b1;
    tick();
    man_ready = 1'b0;
    bus.i_addr = 64'h2008;
    csr_inv_all = 1'b1;
    samp();
    chk("inv_all_held_p3", ic_inv_all, 0);
    tick();
    csr_inv_all = 1'b0;
    man_ready = 1'b1;
    samp();
    chk("inv_all_held_p4", ic_inv_all, 0);
    tick();
    man_ready = 1'b0;
    bus.i_valid = 1'b0;
    samp();
    chk("inv_all_held_release", ic_inv_all, 0);
    tick();
    samp();
    chk("inv_all_held_idle", ic_inv_all, 0);
    tick();
    samp();
    chk("inv_all_pulse", ic_inv_all, 1);
    tick();
    samp();
    chk("inv_all_pulse_end", ic_inv_all, 0);
    repeat (3) tick();
    chk("inv_all_pulse_count", inv_all_seen - s0, 1);

    // Reset while D owns the bus
    tick();
    push_d(64'h7000, 64'h0, 1'b0, 2'd3);
    bus.d_valid = 1'b1;
    tick();
    samp();
    chk("midrst_pre_m_valid", bus.m_valid, 1);
    tick();
    rst = 1'b1;
    man_ready = 1'b1;
    tick();
    rst = 1'b0;
    bus.d_valid = 1'b0;
    samp();
    chk("midrst_m_valid", bus.m_valid, 0);
    chk("midrst_d_ready", bus.d_ready, 0);
    chk("midrst_stat_i", stat_i_beats, 0);
    chk("midrst_stat_d", stat_d_beats, 0);
    chk("midrst_stat_conf", stat_conflicts, 0);
    tick();
    man_ready = 1'b0;

    // Randomized concurrent traffic with a random bus
    do_reset();
    bus_auto = 1'b1;
    fork
      i_driver(30);
      d_driver(40);
    join
    repeat (5) tick();
    chk("rand_stat_i", stat_i_beats, 60);
    chk("rand_stat_d", stat_d_beats, 40);
    chk("rand_iq_drained", iq.size(), 0);
    chk("rand_dq_drained", dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
